regfile_wb_scheduler: RTL

//  Sequences all writes into the 32x32 integer register file and tracks in-flight destinations.
//  Two writeback requesters share the single register-file write port:
//    A = ALU, B = load unit.

---
 rtl/regfile_wb_if.sv | 44 ++++
 rtl/regfile_wb_scheduler.sv | 123 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_if.sv
// Bundles the issue, writeback-request and register-file write signals of the writeback scheduler.
// The slave modport is the scheduler; the master modport is the issue stage, requesters and regfile.
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rs2;
  logic              iss_ready;

  logic              wb_a_valid;
  logic [ADDR_W-1:0] wb_a_address;
  logic [DATA_W-1:0] wb_a_data;
  logic              wb_a_ready;

  logic              wb_b_valid;
  logic [ADDR_W-1:0] wb_b_address;
  logic [DATA_W-1:0] wb_b_data;
  logic              wb_b_ready;

  logic              wr_enable;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   pending_cnt;
  logic              wb_orphan;

  modport master (
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    output wb_a_valid, wb_a_address, wb_a_data,
    output wb_b_valid, wb_b_address, wb_b_data,
    input  iss_ready, wb_a_ready, wb_b_ready,
    input  wr_enable, wr_address, wr_data, pending_cnt, wb_orphan
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  wb_a_valid, wb_a_address, wb_a_data,
    input  wb_b_valid, wb_b_address, wb_b_data,
    output iss_ready, wb_a_ready, wb_b_ready,
    output wr_enable, wr_address, wr_data, pending_cnt, wb_orphan
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter for the integer register file with a registered write port
// and a per-register busy scoreboard that gates issue on RAW/WAW hazards and outstanding writes.
module regfile_wb_scheduler #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  regfile_wb_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_PEND = (ADDR_W+1)'(MAX_PENDING);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] X0     = '0;

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W:0]   pending_cnt_q, pending_cnt_d;
  grant_e            last_grant_q, last_grant_d;
  logic              wr_enable_q, wr_enable_d;
  logic [ADDR_W-1:0] wr_address_q, wr_address_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wb_orphan_q, wb_orphan_d;

  logic              rs1_busy, rs2_busy, rd_busy, under_cap;
  logic              iss_ready, iss_fire, cnt_inc, cnt_dec;
  logic              grant_a, grant_b, grant_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Issue hazard check; x0 is never reported busy.
  always_comb begin
    rs1_busy  = (bus.iss_rs1 != X0) && busy_q[bus.iss_rs1];
    rs2_busy  = (bus.iss_rs2 != X0) && busy_q[bus.iss_rs2];
    rd_busy   = (bus.iss_rd  != X0) && busy_q[bus.iss_rd];
    under_cap = (pending_cnt_q < MAX_PEND);
    iss_ready = !rs1_busy && !rs2_busy && !rd_busy && under_cap;
    iss_fire  = bus.iss_valid && iss_ready;
  end

  // Round-robin: on contention the side that did not win last time is granted.
  always_comb begin
    grant_a   = bus.wb_a_valid && (!bus.wb_b_valid || (last_grant_q == GNT_B));
    grant_b   = bus.wb_b_valid && (!bus.wb_a_valid || (last_grant_q == GNT_A));
    grant_any = grant_a || grant_b;
    gnt_addr  = grant_b ? bus.wb_b_address : bus.wb_a_address;
    gnt_data  = grant_b ? bus.wb_b_data    : bus.wb_a_data;

    last_grant_d = last_grant_q;
    if (grant_a) begin
      last_grant_d = GNT_A;
    end else if (grant_b) begin
      last_grant_d = GNT_B;
    end
  end

  // Write stage: a grant to x0 is consumed but never enables the register file.
  always_comb begin
    wr_enable_d  = grant_any && (gnt_addr != X0);
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    if (grant_any) begin
      wr_address_d = gnt_addr;
      wr_data_d    = gnt_data;
    end
    wb_orphan_d = wb_orphan_q;
    if (grant_any && (gnt_addr != X0) && !busy_q[gnt_addr]) begin
      wb_orphan_d = 1'b1;
    end
  end

  // Scoreboard: commit clears at the regfile write edge, issue sets the new destination.
  always_comb begin
    cnt_inc = iss_fire && (bus.iss_rd != X0);
    cnt_dec = wr_enable_q && busy_q[wr_address_q];

    busy_d = busy_q;
    if (wr_enable_q) begin
      busy_d[wr_address_q] = 1'b0;
    end
    if (cnt_inc) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    unique case ({cnt_inc, cnt_dec})
      2'b10:   pending_cnt_d = pending_cnt_q + CNT_ONE;
      2'b01:   pending_cnt_d = pending_cnt_q - CNT_ONE;
      default: pending_cnt_d = pending_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
      last_grant_q  <= GNT_B;
      wr_enable_q   <= 1'b0;
      wr_address_q  <= '0;
      wr_data_q     <= '0;
      wb_orphan_q   <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
      last_grant_q  <= last_grant_d;
      wr_enable_q   <= wr_enable_d;
      wr_address_q  <= wr_address_d;
      wr_data_q     <= wr_data_d;
      wb_orphan_q   <= wb_orphan_d;
    end
  end

  assign bus.iss_ready   = iss_ready;
  assign bus.wb_a_ready  = grant_a;
  assign bus.wb_b_ready  = grant_b;
  assign bus.wr_enable   = wr_enable_q;
  assign bus.wr_address  = wr_address_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.pending_cnt = pending_cnt_q;
  assign bus.wb_orphan   = wb_orphan_q;
endmodule
